// File: rtl/dds_freq_meter_pkg.sv
// Shared DDS constants and meter FSM encodings.
// Imported by the meter top, its bus interface and the bench.
package dds_pkg;
    localparam int CLK_HZ  = 12_000_000;
    localparam int PHASE_W = 32;
    localparam int DIV_LAT = PHASE_W + 2;

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_FIRST = 2'd1;
    localparam logic [1:0] S_COUNT      = 2'd2;
endpackage

// File: rtl/dds_freq_meter_if.sv
// Control/result bundle of the frequency meter; master drives en/sig_in, slave returns the tuning word and flags.
// Combinational wires only: no latency, no backpressure.
interface dds_freq_meter_if;
    import dds_pkg::*;

    logic               en;
    logic               sig_in;
    logic [PHASE_W-1:0] m;
    logic               set;
    logic               busy;
    logic               timeout;
    logic               overrun;

    modport master (output en, sig_in, input m, set, busy, timeout, overrun);
    modport slave  (input en, sig_in, output m, set, busy, timeout, overrun);
endinterface

// File: rtl/dds_freq_meter_udiv.sv
// Sequential restoring divider, one quotient bit per cycle; o_done/o_quot are valid during the last iteration cycle.
// Latency DVD_W+1 cycles from start; a start while busy is ignored, i_abort drops the running division.
module udiv_seq #(
    parameter int DVD_W = 33,
    parameter int DVS_W = 24,
    parameter int Q_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [Q_W-1:0]   o_quot
);
    localparam int CW = $clog2(DVD_W + 1);

    logic [DVD_W-1:0] r_q;
    logic [DVS_W-1:0] r_rem;
    logic [DVS_W-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;

    logic [DVS_W:0]   w_trial;
    logic [DVS_W-1:0] w_diff;
    logic             w_ge;
    logic [DVS_W-1:0] w_rem_nxt;
    logic [DVD_W-1:0] w_q_nxt;

    // Remainder stays below the divisor, so the low DVS_W bits of the difference are exact.
    always_comb begin
        w_trial   = {r_rem, r_q[DVD_W-1]};
        w_ge      = (w_trial >= {1'b0, r_dvs});
        w_diff    = w_trial[DVS_W-1:0] - r_dvs;
        w_rem_nxt = w_ge ? w_diff : w_trial[DVS_W-1:0];
        w_q_nxt   = {r_q[DVD_W-2:0], w_ge};
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == CW'(DVD_W - 1));
    assign o_quot = w_q_nxt[Q_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_q    <= i_dividend;
            r_rem  <= '0;
            r_dvs  <= i_divisor;
        end else if (r_busy) begin
            r_q   <= w_q_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (o_done) r_busy <= 1'b0;
        end
    end
endmodule

// File: rtl/dds_freq_meter.sv
// Square-wave period meter -> DDS tuning word floor(2^32/P); set lands 34 cycles after the closing edge (DDS_FREQ_METER_AVG4_EN: 4-period average, 36 cycles).
// No backpressure: a period closing while the divider is busy is dropped and flagged in the sticky overrun.
module dds_freq_meter
    import dds_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic            clk,
    input  logic            rst,
    dds_freq_meter_if.slave bus
);
`ifdef DDS_FREQ_METER_AVG4_EN
    localparam int DVD_W = PHASE_W + 3;
    localparam int DVS_W = CNT_W + 2;
`else
    localparam int DVD_W = PHASE_W + 1;
    localparam int DVS_W = CNT_W;
`endif
    localparam logic [DVD_W-1:0] DIVIDEND = {1'b1, {(DVD_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic               r_s1, r_s2, r_s3;
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_en_d;
    logic [PHASE_W-1:0] r_m;
    logic               r_set, r_timeout, r_overrun;

    logic               w_rise, w_close, w_tmo, w_start;
    logic               w_div_busy, w_div_done;
    logic [PHASE_W-1:0] w_quot;
    logic [DVS_W-1:0]   w_divisor;

    assign w_rise  = r_s2 & ~r_s3;
    assign w_close = bus.en && (r_state == S_COUNT) && w_rise;
    assign w_tmo   = bus.en && (r_state == S_COUNT) && !w_rise && (r_cnt == CNT_MAX);

`ifdef DDS_FREQ_METER_AVG4_EN
    logic [CNT_W+1:0] r_acc;
    logic [CNT_W+1:0] w_sum;
    logic [1:0]       r_nper;

    assign w_sum     = r_acc + {2'b00, r_cnt};
    assign w_start   = w_close && (r_nper == 2'd3);
    assign w_divisor = w_sum;

    always_ff @(posedge clk) begin
        if (rst || !bus.en || (r_state != S_COUNT) || w_tmo) begin
            r_acc  <= '0;
            r_nper <= '0;
        end else if (w_close) begin
            r_acc  <= (r_nper == 2'd3) ? '0 : w_sum;
            r_nper <= r_nper + 2'd1;
        end
    end
`else
    assign w_start   = w_close;
    assign w_divisor = r_cnt;
`endif

    udiv_seq #(
        .DVD_W (DVD_W),
        .DVS_W (DVS_W),
        .Q_W   (PHASE_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_abort    (!bus.en),
        .i_dividend (DIVIDEND),
        .i_divisor  (w_divisor),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quot     (w_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_state   <= S_WAIT_FIRST;
            r_cnt     <= '0;
            r_en_d    <= 1'b0;
            r_m       <= '0;
            r_set     <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_s1   <= bus.sig_in;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_en_d <= bus.en;
            r_set  <= 1'b0;

            if (!bus.en) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_WAIT_FIRST;
                    S_WAIT_FIRST: begin
                        if (w_rise) begin
                            r_state <= S_COUNT;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                    S_COUNT: begin
                        if (w_tmo) begin
                            r_state <= S_WAIT_FIRST;
                            r_cnt   <= '0;
                        end else if (w_rise) begin
                            r_cnt <= CNT_W'(1);
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            if (bus.en && !r_en_d) begin
                r_timeout <= 1'b0;
                r_overrun <= 1'b0;
            end else begin
                if (w_tmo) r_timeout <= 1'b1;
                if (w_start && w_div_busy) r_overrun <= 1'b1;
            end

            // Timeout result beats a division finishing in the same cycle.
            if (w_tmo) begin
                r_m   <= '0;
                r_set <= 1'b1;
            end else if (bus.en && w_div_done) begin
                r_m   <= w_quot;
                r_set <= 1'b1;
            end
        end
    end

    assign bus.m       = r_m;
    assign bus.set     = r_set;
    assign bus.busy    = w_div_busy;
    assign bus.timeout = r_timeout;
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_dds_freq_meter.sv
// Directed bench: wide-counter meter for tone/overrun/abort cases, CNT_W=8 meter for timeout.
module tb_dds_freq_meter;
    import dds_pkg::*;

    // drive-to-set: two synchronizer cycles before rise, then the divider latency
    localparam int LAT = 2 + DIV_LAT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dds_freq_meter_if bif_a();
    dds_freq_meter_if bif_b();

    dds_freq_meter #(.CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bif_a));
    dds_freq_meter #(.CNT_W(8))  dut_b (.clk(clk), .rst(rst), .bus(bif_b));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ea[$];
    int eb[$];
    int sa_cyc[$];
    int sb_cyc[$];
    logic [31:0] sa_m[$];
    logic [31:0] sb_m[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (bif_a.set === 1'b1) begin sa_cyc.push_back(cyc); sa_m.push_back(bif_a.m); end
        if (bif_b.set === 1'b1) begin sb_cyc.push_back(cyc); sb_m.push_back(bif_b.m); end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full period of n cycles starting with a rising edge; b selects the meter.
    task automatic sq(input bit b, input int n);
        if (b) begin bif_b.sig_in = 1'b1; eb.push_back(cyc); end
        else   begin bif_a.sig_in = 1'b1; ea.push_back(cyc); end
        tick(n / 2);
        if (b) bif_b.sig_in = 1'b0; else bif_a.sig_in = 1'b0;
        tick(n - n / 2);
    endtask

    task automatic clear_logs();
        ea.delete(); eb.delete();
        sa_cyc.delete(); sa_m.delete(); sb_cyc.delete(); sb_m.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif_a.en = 1'b0; bif_a.sig_in = 1'b0;
        bif_b.en = 1'b0; bif_b.sig_in = 1'b0;
        tick(3);
        n_tests++; if (bif_a.m !== 32'd0) begin n_fail++; $display("FAIL reset_m: got %0d want 0", bif_a.m); end
        n_tests++; if (bif_a.set !== 1'b0) begin n_fail++; $display("FAIL reset_set: got %b want 0", bif_a.set); end
        n_tests++; if (bif_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bif_a.busy); end
        n_tests++; if (bif_a.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", bif_a.timeout); end
        n_tests++; if (bif_a.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", bif_a.overrun); end
        n_tests++; if (bif_b.m !== 32'd0) begin n_fail++; $display("FAIL reset_m_b: got %0d want 0", bif_b.m); end
        rst = 1'b0;
        bif_a.en = 1'b1;
        bif_b.en = 1'b1;
        tick(3);
    endtask

    task automatic test_440();
        clear_logs();
        sq(1'b0, 27272);
        sq(1'b0, 27272);
        n_tests++; if (sa_m.size() != 1) begin n_fail++; $display("FAIL t440_count: got %0d sets want 1", sa_m.size()); end
        else begin
            n_tests++; if (sa_m[0] !== 32'd157486) begin n_fail++; $display("FAIL t440_m: got %0d want 157486", sa_m[0]); end
            n_tests++; if (sa_cyc[0] - ea[1] != LAT) begin n_fail++; $display("FAIL t440_lat: got %0d want %0d", sa_cyc[0] - ea[1], LAT); end
        end
        n_tests++; if (bif_a.overrun !== 1'b0) begin n_fail++; $display("FAIL t440_overrun: got %b want 0", bif_a.overrun); end
    endtask

    task automatic test_880_overrun();
        clear_logs();
        sq(1'b0, 13636);
        n_tests++; if (bif_a.overrun !== 1'b0) begin n_fail++; $display("FAIL t880_overrun: got %b want 0", bif_a.overrun); end
        for (int i = 0; i < 6; i++) sq(1'b0, 3);
        sq(1'b0, 4096);
        sq(1'b0, 50);
        tick(30);
        n_tests++; if (sa_m.size() != 3) begin n_fail++; $display("FAIL ovr_count: got %0d sets want 3", sa_m.size()); end
        else begin
            n_tests++; if (sa_m[0] !== 32'd157486) begin n_fail++; $display("FAIL t440_repeat_m: got %0d want 157486", sa_m[0]); end
            n_tests++; if (sa_cyc[0] - ea[0] != LAT) begin n_fail++; $display("FAIL t440_repeat_lat: got %0d want %0d", sa_cyc[0] - ea[0], LAT); end
            n_tests++; if (sa_m[1] !== 32'd314972) begin n_fail++; $display("FAIL t880_m: got %0d want 314972", sa_m[1]); end
            n_tests++; if (sa_cyc[1] - ea[1] != LAT) begin n_fail++; $display("FAIL t880_lat: got %0d want %0d", sa_cyc[1] - ea[1], LAT); end
            n_tests++; if (sa_m[2] !== 32'd1048576) begin n_fail++; $display("FAIL t4096_m: got %0d want 1048576", sa_m[2]); end
            n_tests++; if (sa_cyc[2] - ea[8] != LAT) begin n_fail++; $display("FAIL t4096_lat: got %0d want %0d", sa_cyc[2] - ea[8], LAT); end
        end
        n_tests++; if (bif_a.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", bif_a.overrun); end
    endtask

    task automatic test_timeout();
        clear_logs();
        sq(1'b1, 100);
        sq(1'b1, 100);
        tick(200);
        n_tests++; if (sb_m.size() != 2) begin n_fail++; $display("FAIL tmo_count: got %0d sets want 2", sb_m.size()); end
        else begin
            n_tests++; if (sb_m[0] !== 32'd42949672) begin n_fail++; $display("FAIL tmo_pre_m: got %0d want 42949672", sb_m[0]); end
            n_tests++; if (sb_cyc[0] - eb[1] != LAT) begin n_fail++; $display("FAIL tmo_pre_lat: got %0d want %0d", sb_cyc[0] - eb[1], LAT); end
            n_tests++; if (sb_m[1] !== 32'd0) begin n_fail++; $display("FAIL tmo_m: got %0d want 0", sb_m[1]); end
            n_tests++; if (sb_cyc[1] - eb[1] != 258) begin n_fail++; $display("FAIL tmo_lat: got %0d want 258", sb_cyc[1] - eb[1]); end
        end
        n_tests++; if (bif_b.timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b want 1", bif_b.timeout); end
        clear_logs();
        sq(1'b1, 200);
        sq(1'b1, 200);
        n_tests++; if (sb_m.size() != 1) begin n_fail++; $display("FAIL tmo_resume_count: got %0d sets want 1", sb_m.size()); end
        else begin
            n_tests++; if (sb_m[0] !== 32'd21474836) begin n_fail++; $display("FAIL tmo_resume_m: got %0d want 21474836", sb_m[0]); end
            n_tests++; if (sb_cyc[0] - eb[1] != LAT) begin n_fail++; $display("FAIL tmo_resume_lat: got %0d want %0d", sb_cyc[0] - eb[1], LAT); end
        end
        bif_b.en = 1'b0;
        tick(2);
        n_tests++; if (bif_b.timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", bif_b.timeout); end
        bif_b.en = 1'b1;
        tick(2);
        n_tests++; if (bif_b.timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_en_clear: got %b want 0", bif_b.timeout); end
    endtask

    task automatic test_en_abort();
        clear_logs();
        sq(1'b0, 20);
        n_tests++; if (bif_a.busy !== 1'b1) begin n_fail++; $display("FAIL en_busy_pre: got %b want 1", bif_a.busy); end
        bif_a.en = 1'b0;
        tick(2);
        n_tests++; if (bif_a.busy !== 1'b0) begin n_fail++; $display("FAIL en_busy_post: got %b want 0", bif_a.busy); end
        tick(60);
        n_tests++; if (sa_m.size() != 0) begin n_fail++; $display("FAIL en_no_set: got %0d sets want 0", sa_m.size()); end
        n_tests++; if (bif_a.m !== 32'd1048576) begin n_fail++; $display("FAIL en_m_hold: got %0d want 1048576", bif_a.m); end
        n_tests++; if (bif_a.overrun !== 1'b1) begin n_fail++; $display("FAIL en_ovr_sticky: got %b want 1", bif_a.overrun); end
        bif_a.en = 1'b1;
        tick(2);
        n_tests++; if (bif_a.overrun !== 1'b0) begin n_fail++; $display("FAIL en_ovr_clear: got %b want 0", bif_a.overrun); end
    endtask

    task automatic test_rst_abort();
        clear_logs();
        sq(1'b0, 40);
        sq(1'b0, 3);
        sq(1'b0, 3);
        sq(1'b0, 3);
        n_tests++; if (bif_a.overrun !== 1'b1) begin n_fail++; $display("FAIL rst_ovr_pre: got %b want 1", bif_a.overrun); end
        n_tests++; if (bif_a.busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_pre: got %b want 1", bif_a.busy); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        n_tests++; if (bif_a.m !== 32'd0) begin n_fail++; $display("FAIL rst_m: got %0d want 0", bif_a.m); end
        n_tests++; if (bif_a.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bif_a.busy); end
        n_tests++; if (bif_a.overrun !== 1'b0) begin n_fail++; $display("FAIL rst_ovr: got %b want 0", bif_a.overrun); end
        n_tests++; if (bif_b.m !== 32'd0) begin n_fail++; $display("FAIL rst_m_b: got %0d want 0", bif_b.m); end
        tick(50);
        n_tests++; if (sa_m.size() != 0) begin n_fail++; $display("FAIL rst_no_set: got %0d sets want 0", sa_m.size()); end
    endtask

    initial begin
        test_reset();
        test_440();
        test_880_overrun();
        test_timeout();
        test_en_abort();
        test_rst_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
